// File: rtl/audioqsys_adc_pkg.sv
// Shared constants and FSM state type for the I2S ADC receiver.
// Holds the register map, the status/control bit positions and the deserializer states.
package audioqsys_adc_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_LEFT   = 2'd2;
  localparam logic [1:0] ADDR_RIGHT  = 2'd3;

  localparam int OVF_BIT     = 16;
  localparam int CLR_OVF_BIT = 1;
  localparam int EN_BIT      = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_SKIP  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

endpackage

// File: rtl/audioqsys_adc_i2s_rx_if.sv
// Avalon-MM slave bus of the I2S ADC receiver, plus its FSM state for observation.
// Handshake: no waitrequest; read/write are accepted in the cycle they are high and readdata is valid one cycle after the read.
interface audioqsys_adc_i2s_rx_if;
  import audioqsys_adc_pkg::*;

  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  state_e      dbg_state;

  modport slave  (input address, read, write, writedata, output readdata, dbg_state);
  modport master (output address, read, write, writedata, input readdata, dbg_state);

endinterface

// File: rtl/audioqsys_adc_fifo.sv
// Show-ahead synchronous FIFO holding {left, right} sample pairs.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module audioqsys_adc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_level == LW'(DEPTH));
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/audioqsys_adc_i2s_rx.sv
// I2S ADC deserializer: synchronizes codec pins, assembles stereo words MSB first
// and queues {left, right} pairs for the CPU behind a 4-register Avalon-MM slave.
module audioqsys_adc_i2s_rx
  import audioqsys_adc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  audioqsys_adc_i2s_rx_if.slave avs,
  input  logic                 adc_bclk,
  input  logic                 adc_lrck,
  input  logic                 adc_dat
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrck_sync, r_dat_sync;
  logic w_bclk_s, w_lrck_s, w_dat_s;
  logic r_bclk_d, r_lrck_d;
  logic r_bclk_rise, r_lrck_rise, r_lrck_fall, r_dat;

  state_e             r_state, w_next;
  logic               w_word_done;
  logic [CW-1:0]      r_bit_cnt;
  logic               r_is_right;
  logic [DATA_W-1:0]  r_shift, r_left, w_word;
  logic               r_push;
  logic [2*DATA_W-1:0] r_push_data;

  logic               r_enable, r_ovf;
  logic [31:0]        r_readdata, w_rdata;
  logic               w_pop, w_full, w_empty, w_drop;
  logic [LW-1:0]      w_level;
  logic [2*DATA_W-1:0] w_head;
  logic signed [DATA_W-1:0] w_head_l, w_head_r;
  logic               w_unused_wdata;

  assign w_bclk_s = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrck_s = r_lrck_sync[SYNC_STAGES-1];
  assign w_dat_s  = r_dat_sync[SYNC_STAGES-1];

  // Strobes and the data sample are registered together so they stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
      r_bclk_d    <= 1'b0;
      r_lrck_d    <= 1'b0;
      r_bclk_rise <= 1'b0;
      r_lrck_rise <= 1'b0;
      r_lrck_fall <= 1'b0;
      r_dat       <= 1'b0;
    end else begin
      r_bclk_sync <= (r_bclk_sync << 1) | SYNC_STAGES'(adc_bclk);
      r_lrck_sync <= (r_lrck_sync << 1) | SYNC_STAGES'(adc_lrck);
      r_dat_sync  <= (r_dat_sync << 1) | SYNC_STAGES'(adc_dat);
      r_bclk_d    <= w_bclk_s;
      r_lrck_d    <= w_lrck_s;
      r_bclk_rise <= w_bclk_s & ~r_bclk_d;
      r_lrck_rise <= w_lrck_s & ~r_lrck_d;
      r_lrck_fall <= ~w_lrck_s & r_lrck_d;
      r_dat       <= w_dat_s;
    end
  end

  assign w_word = {r_shift[DATA_W-2:0], r_dat};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // LRCK edges are watched every clk; SKIP then swallows the one-bit I2S delay.
  always_comb begin
    w_next      = r_state;
    w_word_done = 1'b0;
    if (!r_enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_ALIGN;
        ST_ALIGN: if (r_lrck_fall) w_next = ST_SKIP;
        ST_SKIP:  if (r_bclk_rise) w_next = ST_SHIFT;
        ST_SHIFT: begin
          if (r_bclk_rise && r_bit_cnt == BIT_LAST) begin
            w_next      = ST_WAIT;
            w_word_done = 1'b1;
          end
        end
        ST_WAIT:  if (r_lrck_rise || r_lrck_fall) w_next = ST_SKIP;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= '0;
      r_is_right  <= 1'b0;
      r_shift     <= '0;
      r_left      <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      if (!r_enable) begin
        r_shift   <= '0;
        r_left    <= '0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_ALIGN: if (r_lrck_fall) r_is_right <= 1'b0;
          ST_SKIP:  r_bit_cnt <= '0;
          ST_SHIFT: begin
            if (r_bclk_rise) begin
              r_shift   <= w_word;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            if (r_lrck_rise)      r_is_right <= 1'b1;
            else if (r_lrck_fall) r_is_right <= 1'b0;
          end
          default: ;
        endcase
        if (w_word_done) begin
          if (r_is_right) begin
            r_push      <= 1'b1;
            r_push_data <= {r_left, w_word};
          end else begin
            r_left <= w_word;
          end
        end
      end
    end
  end

  assign w_pop  = avs.read && (avs.address == ADDR_RIGHT) && !w_empty;
  assign w_drop = r_push & w_full & ~w_pop;

  audioqsys_adc_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_head  (w_head)
  );

  assign w_head_l = w_head[2*DATA_W-1:DATA_W];
  assign w_head_r = w_head[DATA_W-1:0];

  always_comb begin
    w_rdata = '0;
    case (avs.address)
      ADDR_STATUS: begin
        w_rdata          = 32'(w_level);
        w_rdata[OVF_BIT] = r_ovf;
      end
      ADDR_CTRL:  w_rdata[EN_BIT] = r_enable;
      ADDR_LEFT:  if (!w_empty) w_rdata = 32'(w_head_l);
      ADDR_RIGHT: if (!w_empty) w_rdata = 32'(w_head_r);
      default:    w_rdata = '0;
    endcase
  end

  // An overflow in the same cycle as a W1C clear leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable   <= 1'b0;
      r_ovf      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
      if (avs.write && avs.address == ADDR_CTRL) r_enable <= avs.writedata[EN_BIT];
      if (w_drop) r_ovf <= 1'b1;
      else if (avs.write && avs.address == ADDR_STATUS && avs.writedata[CLR_OVF_BIT]) r_ovf <= 1'b0;
    end
  end

  assign avs.readdata  = r_readdata;
  assign avs.dbg_state = r_state;
  assign w_unused_wdata = ^avs.writedata[31:2];

endmodule

// File: tb/tb_audioqsys_adc_i2s_rx.sv
// Bench for the I2S ADC receiver: register table, directed frames and random
// frames checked against a pair-queue model of the FIFO and overflow flag.
module tb_audioqsys_adc_i2s_rx;
  import audioqsys_adc_pkg::*;

  localparam int DATA_W      = 16;
  localparam int FIFO_DEPTH  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF_SLOTS  = 32;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic adc_bclk = 1'b0;
  logic adc_lrck = 1'b1;
  logic adc_dat  = 1'b0;

  audioqsys_adc_i2s_rx_if avs();

  audioqsys_adc_i2s_rx #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (avs),
    .adc_bclk (adc_bclk),
    .adc_lrck (adc_lrck),
    .adc_dat  (adc_dat)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    #800000;
    n_errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard model ----------------
  logic [2*DATA_W-1:0] exp_q[$];
  logic                exp_ovf = 1'b0;
  event                lsb_rise_ev;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic model_push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({l, r});
    else exp_ovf = 1'b1;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(exp_q.size());
    s[16] = exp_ovf;
    return s;
  endfunction

  function automatic logic [31:0] sext(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    return 32'(sv);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs.address = a; avs.write = 1'b1; avs.writedata = d;
    @(negedge clk);
    avs.write = 1'b0;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs.address = a; avs.read = 1'b1;
    @(negedge clk);
    avs.read = 1'b0;
    d = avs.readdata;
  endtask

  // One I2S frame, BCLK = clk/8, 32 BCLKs per half; MSB on the 2nd rise after LRCK changes.
  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int idx;
    logic [DATA_W-1:0] w;
    @(negedge clk);
    for (int k = 0; k < 2 * HALF_SLOTS; k++) begin
      idx = k % HALF_SLOTS;
      w   = (k < HALF_SLOTS) ? l : r;
      adc_bclk = 1'b0;
      adc_lrck = (k >= HALF_SLOTS);
      adc_dat  = (idx >= 1 && idx <= DATA_W) ? w[DATA_W - idx] : 1'b0;
      repeat (4) @(negedge clk);
      adc_bclk = 1'b1;
      if (k == HALF_SLOTS + DATA_W) -> lsb_rise_ev;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic check_status(input string name);
    logic [31:0] d;
    av_read(ADDR_STATUS, d);
    check(name, d, exp_status());
  endtask

  task automatic check_pop(input string name);
    logic [31:0] d;
    logic [2*DATA_W-1:0] h;
    h = exp_q[0];
    av_read(ADDR_LEFT, d);
    check({name, "_left"}, d, sext(h[2*DATA_W-1:DATA_W]));
    av_read(ADDR_RIGHT, d);
    check({name, "_right"}, d, sext(h[DATA_W-1:0]));
    void'(exp_q.pop_front());
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic [1:0]  addr;
    logic        is_write;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] d;
    logic [DATA_W-1:0] l, r, first_l;
    int nf;

    vecs[0]  = '{ADDR_STATUS, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{ADDR_CTRL,   1'b0, 32'h0, 32'h0};
    vecs[2]  = '{ADDR_LEFT,   1'b0, 32'h0, 32'h0};
    vecs[3]  = '{ADDR_RIGHT,  1'b0, 32'h0, 32'h0};
    vecs[4]  = '{ADDR_CTRL,   1'b1, 32'h1, 32'h0};
    vecs[5]  = '{ADDR_CTRL,   1'b0, 32'h0, 32'h1};
    vecs[6]  = '{ADDR_CTRL,   1'b1, 32'hFFFF_FFFE, 32'h0};
    vecs[7]  = '{ADDR_CTRL,   1'b0, 32'h0, 32'h0};
    vecs[8]  = '{ADDR_STATUS, 1'b1, 32'h2, 32'h0};
    vecs[9]  = '{ADDR_STATUS, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{ADDR_CTRL,   1'b1, 32'h1, 32'h0};
    vecs[11] = '{ADDR_CTRL,   1'b0, 32'h0, 32'h1};

    avs.address = 2'd0; avs.read = 1'b0; avs.write = 1'b0; avs.writedata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_readdata", avs.readdata, 32'h0);
    check("reset_state", 32'(avs.dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_write) av_write(vecs[i].addr, vecs[i].wdata);
      else begin
        av_read(vecs[i].addr, d);
        check($sformatf("table_%0d", i), d, vecs[i].exp);
      end
    end

    // Basic frame with known values.
    send_frame(16'h1234, 16'hABCD);
    model_push(16'h1234, 16'hABCD);
    av_read(ADDR_STATUS, d);
    check("basic_level", d, 32'h1);
    av_read(ADDR_LEFT, d);
    check("basic_left", d, 32'h0000_1234);
    av_read(ADDR_RIGHT, d);
    check("basic_right", d, 32'hFFFF_ABCD);
    void'(exp_q.pop_front());
    av_read(ADDR_STATUS, d);
    check("basic_level_after", d, 32'h0);

    // Random frames, then drain.
    nf = $urandom_range(3, 6);
    for (int i = 0; i < nf; i++) begin
      l = DATA_W'($urandom_range(0, 65535));
      r = DATA_W'($urandom_range(0, 65535));
      send_frame(l, r);
      model_push(l, r);
    end
    check_status("rand_status");
    while (exp_q.size() > 0) check_pop("rand_pop");
    check_status("rand_drained");

    // Empty reads return zero and do not pop.
    av_read(ADDR_LEFT, d);
    check("empty_left", d, 32'h0);
    av_read(ADDR_RIGHT, d);
    check("empty_right", d, 32'h0);
    check_status("empty_status");

    // Overflow: one more frame than the FIFO holds.
    first_l = 16'h0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      l = DATA_W'($urandom_range(0, 65535));
      r = DATA_W'($urandom_range(0, 65535));
      if (i == 0) first_l = l;
      send_frame(l, r);
      model_push(l, r);
    end
    check_status("ovf_status");
    av_read(ADDR_LEFT, d);
    check("ovf_head_left", d, sext(first_l));
    av_write(ADDR_STATUS, 32'h2);
    exp_ovf = 1'b0;
    check_status("ovf_cleared");

    // Pop timed onto the push cycle while full.
    l = DATA_W'($urandom_range(0, 65535));
    r = DATA_W'($urandom_range(0, 65535));
    fork
      send_frame(l, r);
      begin
        logic [31:0] sd;
        logic [2*DATA_W-1:0] h;
        h = exp_q[0];
        @(lsb_rise_ev);
        repeat (SYNC_STAGES + 1) @(negedge clk);
        av_read(ADDR_RIGHT, sd);
        check("simul_pop_data", sd, sext(h[DATA_W-1:0]));
        void'(exp_q.pop_front());
      end
    join
    model_push(l, r);
    check_status("simul_status");
    while (exp_q.size() > 0) check_pop("simul_drain");

    // Disable in the middle of the left word, re-enable before the frame ends.
    fork
      send_frame(DATA_W'($urandom_range(0, 65535)), DATA_W'($urandom_range(0, 65535)));
      begin
        repeat (70) @(negedge clk);
        av_write(ADDR_CTRL, 32'h0);
        repeat (30) @(negedge clk);
        av_write(ADDR_CTRL, 32'h1);
      end
    join
    check_status("disable_nothing_pushed");
    l = DATA_W'($urandom_range(0, 65535));
    r = DATA_W'($urandom_range(0, 65535));
    send_frame(l, r);
    model_push(l, r);
    check_status("reenable_status");
    check_pop("reenable_pop");

    // Reset while shifting, with one pair already queued.
    l = DATA_W'($urandom_range(0, 65535));
    r = DATA_W'($urandom_range(0, 65535));
    send_frame(l, r);
    model_push(l, r);
    check_status("prereset_status");
    fork
      send_frame(DATA_W'($urandom_range(0, 65535)), DATA_W'($urandom_range(0, 65535)));
      begin
        repeat (80) @(negedge clk);
        check("prereset_state", 32'(avs.dbg_state), 32'(ST_SHIFT));
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_readdata", avs.readdata, 32'h0);
        check("midreset_state", 32'(avs.dbg_state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    exp_q.delete();
    exp_ovf = 1'b0;
    check_status("postreset_status");
    av_read(ADDR_CTRL, d);
    check("postreset_enable", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/audioqsys_adc_i2s_rx.md
# audioqsys_adc_i2s_rx

Avalon-MM slave that deserializes the audio codec's I2S ADC stream (BCLK, ADCLRCK, ADCDAT) into stereo PCM sample pairs. It buffers the pairs in a small FIFO for the Nios II CPU. It sits between the codec pins and the system interconnect, alongside the raw ADC_DATA PIO. Software then reads whole samples instead of bit-banging the data line.

## Interface
Parameters:
- DATA_W, 16: bits per channel word, 16..32.
- FIFO_DEPTH, 16: stereo pairs buffered; power of 2, at least 2.
- SYNC_STAGES, 2: flip-flop stages on each asynchronous pin input.

Ports:
- clk, input, 1: system clock. The only clock; must be at least 4× BCLK.
- reset_n, input, 1: asynchronous, active-low reset.
- address, input, 2: register select.
- read, input, 1: read strobe; used only for the pop side effect.
- write, input, 1: write strobe.
- writedata, input, 32: write data.
- readdata, output, 32: registered read data; reset value 0.
- adc_bclk, input, 1: codec bit clock; asynchronous to clk.
- adc_lrck, input, 1: codec L/R clock. Low selects left; asynchronous.
- adc_dat, input, 1: codec serial data; asynchronous.

## Operation
- Each pin input passes through SYNC_STAGES flip-flops, then one edge-detect register. A BCLK rising edge produces a one-clk strobe, bclk_rise.
- All bit-level actions happen only on bclk_rise cycles.
- I2S framing:
  - The MSB arrives on the second BCLK rising edge after an LRCK transition.
  - DATA_W bits are captured MSB first.
  - Any remaining bits in the half-frame are ignored.
- FSM states:
  - IDLE: entered on reset or when enable=0. Moves to ALIGN when enable=1.
  - ALIGN: waits for an LRCK falling edge (start of the left channel). Moves to SKIP.
  - SKIP: waits one bclk_rise. Moves to SHIFT.
  - SHIFT: shifts DATA_W bits; a bit counter counts 0..DATA_W-1. Moves to WAIT.
  - WAIT: waits for the next LRCK edge. A rising edge means right channel: go to SKIP. A falling edge means a new left channel: go to SKIP.
- Word completion:
  - A completed left word is latched into a holding register.
  - A completed right word pushes {left, right} into the FIFO.
- FIFO full at push time:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the pair is dropped and the sticky overflow flag is set.
- Register map:
  - Address 0, read: bit 16 = overflow, bits 15:0 = fill level. Write: writing 1 to bit 1 clears overflow (W1C).
  - Address 1, read/write: bit 0 = enable. Reset value 0.
  - Address 2, read: head left sample, sign-extended to 32 bits. No side effect.
  - Address 3, read: head right sample, sign-extended. A read with address=3 and FIFO non-empty pops the head pair.
  - Reads of data registers while the FIFO is empty return 0 and do not pop.
- Clearing enable mid-word:
  - The FSM goes to IDLE at once and the partial word and held left word are discarded.
  - FIFO contents and overflow are kept.
- Reset clears everything: FSM, shift register, FIFO pointers, overflow, enable, readdata.

## Timing
- Pin to bclk_rise latency is SYNC_STAGES+1 clk cycles.
- The FIFO push happens in the clk cycle after the bclk_rise that captures the right word's LSB.
- The fill level reflects the push one cycle after that.
- readdata is valid on the cycle after address and read are presented (1-cycle read latency). It updates every cycle from the address, following the PIO convention.
- A pop takes effect on the clk edge at the end of the read cycle. The next read of address 2 sees the new head.
- Push and pop in the same cycle leave the fill level unchanged.
- An overflow set and a W1C clear in the same cycle leave overflow = 1 (set wins).

## Structure
- Package audioqsys_adc_pkg holds:
  - register address constants;
  - status bit positions (OVF_BIT = 16, CLR_OVF_BIT = 1, EN_BIT = 0);
  - the FSM state enum.
- Sub-module audioqsys_adc_fifo: a synchronous FIFO of width 2×DATA_W and depth FIFO_DEPTH. It provides push, pop, full, empty, level, and a head output (show-ahead).

## Test plan
- Basic frame: enable, drive one I2S frame at BCLK = clk/8 with L=0x1234, R=0xABCD. Required response: status level = 1, addr2 = 0x00001234, addr3 = 0xFFFFABCD, then level = 0.
- Overflow: send 17 frames with no reads. Required response: level = 16, status bit 16 = 1, head still equals frame 1. Writing 0x2 to address 0 then clears bit 16.
- Disable mid-frame: clear enable halfway through a left word, then re-enable. Required response: nothing pushed; the next complete frame is captured correctly after a fresh LRCK falling edge.
- Read with FIFO empty: addr2 and addr3 return 0 and level stays 0.
- Simultaneous push and pop: time an addr3 read onto the push cycle with level = 16. Required response: level stays 16 and overflow stays 0.
- Reset mid-word: assert reset_n low during SHIFT. Required response: readdata = 0, level = 0, enable = 0, and no spurious push after release.
